// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 32 x N register file, two async reads, one sync write.
// Ports: clk, rst_n, wr_ena/wr_addr/wr_data, rd_addr0/rd_data0, rd_addr1/rd_data1.

module mux32 #(
  parameter int N = 32
) (
  input  logic [31:0][N-1:0] in,
  input  logic [4:0]         sel,
  output logic [N-1:0]       out
);

  assign out = in[sel];

endmodule

module wr_decode (
  input  logic        ena,
  input  logic [4:0]  addr,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (ena) begin
      onehot[addr] = 1'b1;
    end
    // x0 has no storage, so it is never enabled
    onehot[0] = 1'b0;
  end

endmodule

module register_file_2r1w #(
  parameter int N      = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_ena,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [4:0]   rd_addr1,
  output logic [N-1:0] rd_data1
);

  logic [31:0]        wr_sel;
  logic [31:0][N-1:0] regs_q;
  logic [N-1:0]       mux_out0;
  logic [N-1:0]       mux_out1;

  wr_decode u_dec (
    .ena    (wr_ena),
    .addr   (wr_addr),
    .onehot (wr_sel)
  );

  assign regs_q[0] = '0;

  for (genvar i = 1; i < 32; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[i] <= '0;
      end else if (wr_sel[i]) begin
        regs_q[i] <= wr_data;
      end
    end
  end

  mux32 #(.N(N)) u_mux0 (
    .in  (regs_q),
    .sel (rd_addr0),
    .out (mux_out0)
  );

  mux32 #(.N(N)) u_mux1 (
    .in  (regs_q),
    .sel (rd_addr1),
    .out (mux_out1)
  );

  if (BYPASS) begin : g_byp
    logic hit0;
    logic hit1;

    // wr_sel is already zero for x0 and when
    // wr_ena is low; rst_n keeps reset reads at 0
    assign hit0 = rst_n && wr_sel[rd_addr0];
    assign hit1 = rst_n && wr_sel[rd_addr1];

    assign rd_data0 = hit0 ? wr_data : mux_out0;
    assign rd_data1 = hit1 ? wr_data : mux_out1;
  end else begin : g_nobyp
    assign rd_data0 = mux_out0;
    assign rd_data1 = mux_out1;
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: checks BYPASS=0 and BYPASS=1 register files
// against an array model using directed and random stimulus.

module tb_register_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] a_rd0, a_rd1;
  logic [31:0] b_rd0, b_rd1;

  logic [31:0] mem [32];

  int n_tests;
  int n_fail;

  register_file_2r1w #(.N(32), .BYPASS(1'b0)) u_nob (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (a_rd0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (a_rd1)
  );

  register_file_2r1w #(.N(32), .BYPASS(1'b1)) u_byp (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (b_rd0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (b_rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(
    input logic [4:0] a,
    input bit         byp
  );
    if (!rst_n || a == 5'd0) return 32'h0;
    if (byp && wr_ena && wr_addr == a)
      return wr_data;
    return mem[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".a0"}, a_rd0, exp_rd(rd_addr0, 1'b0));
    check({tag, ".a1"}, a_rd1, exp_rd(rd_addr1, 1'b0));
    check({tag, ".b0"}, b_rd0, exp_rd(rd_addr0, 1'b1));
    check({tag, ".b1"}, b_rd1, exp_rd(rd_addr1, 1'b1));
  endtask

  // one rising edge; model follows the write rule
  task automatic tick();
    @(posedge clk);
    if (rst_n && wr_ena && wr_addr != 5'd0)
      mem[wr_addr] = wr_data;
    #1;
  endtask

  task automatic sweep(input string tag);
    wr_ena = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(31 - a);
      #1;
      check_all($sformatf("%s[%0d]", tag, a));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    wr_ena   = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;
    clear_model();

    // reset state
    #2;
    sweep("rst_init");
    tick();
    #2 rst_n = 1'b1;
    #1;

    // reset mid-cycle after writing x5
    wr_ena  = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_ena   = 1'b0;
    rd_addr0 = 5'd5;
    #1;
    check("x5_wr", a_rd0, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_x5_a", a_rd0, 32'h0);
    check("rst_x5_b", b_rd0, 32'h0);
    // write attempted while held in reset
    wr_ena  = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'hCAFEF00D;
    rd_addr0 = 5'd12;
    #1;
    check("rst_byp", b_rd0, 32'h0);
    tick();
    sweep("rst_held");
    #2 rst_n = 1'b1;
    #1;
    sweep("rst_rel");

    // write all
    for (int i = 1; i < 32; i++) begin
      wr_ena  = 1'b1;
      wr_addr = 5'(i);
      wr_data = 32'h1000_0000 + i;
      tick();
    end
    wr_ena = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(31 - a);
      #1;
      check($sformatf("wall0[%0d]", a), a_rd0,
            (a == 0) ? 32'h0 : 32'h1000_0000 + a);
      check($sformatf("wall1[%0d]", a), a_rd1,
            (a == 31) ? 32'h0 :
            32'h1000_0000 + (31 - a));
    end

    // x0 immunity
    wr_ena   = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'hFFFF_FFFF;
    rd_addr0 = 5'd0;
    #1;
    check("x0_pre_a", a_rd0, 32'h0);
    check("x0_pre_b", b_rd0, 32'h0);
    tick();
    sweep("x0_imm");

    // write enable gating
    wr_addr = 5'd7;
    wr_data = 32'h1234_5678;
    rd_addr0 = 5'd7;
    rd_addr1 = 5'd7;
    for (int c = 0; c < 3; c++) begin
      wr_ena = 1'b0;
      tick();
      check("gate_a", a_rd0, 32'h1000_0007);
      check("gate_b", b_rd1, 32'h1000_0007);
    end

    // read during write
    wr_ena  = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hAAAA_AAAA;
    tick();
    wr_data  = 32'h5555_5555;
    rd_addr0 = 5'd9;
    rd_addr1 = 5'd9;
    #1;
    check("rdw_nb0", a_rd0, 32'hAAAA_AAAA);
    check("rdw_nb1", a_rd1, 32'hAAAA_AAAA);
    check("rdw_b0", b_rd0, 32'h5555_5555);
    check("rdw_b1", b_rd1, 32'h5555_5555);
    tick();
    wr_ena = 1'b0;
    #1;
    check("rdw_post_a0", a_rd0, 32'h5555_5555);
    check("rdw_post_a1", a_rd1, 32'h5555_5555);
    check("rdw_post_b0", b_rd0, 32'h5555_5555);
    wr_ena   = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h5555_5555;
    rd_addr0 = 5'd0;
    #1;
    check("rdw_x0_b", b_rd0, 32'h0);
    check("rdw_x0_a", a_rd0, 32'h0);
    tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      wr_ena   = ($urandom_range(0, 3) != 0);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_addr0 = ($urandom_range(0, 3) == 0) ?
                 wr_addr : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 3) == 0) ?
                 wr_addr : 5'($urandom_range(0, 31));
      #1;
      check_all("rnd_pre");
      tick();
      check_all("rnd_post");
    end
    sweep("final");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- 32-entry register file with two asynchronous read ports and one synchronous write port.
- Sits directly upstream of the 32:1 mux. Each read port is one mux32 instance, parameterised N = data width, fed by the 32 register outputs and selected by that port's read address.
- Register 0 is hardwired to zero (RISC-V x0 convention).
- Feeds operand values into the execute stage of the single-cycle/multicycle core.

Parameters:
- N, 32, data width of each register and of every data port.
- BYPASS, 0, when 1 a same-cycle write is forwarded to any read port addressing the written register.

Ports:
- clk  input  1  Single clock; all register updates on rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- wr_ena  input  1  Write enable, sampled on rising clk.
- wr_addr  input  5  Register index to write.
- wr_data  input  N  Data to write.
- rd_addr0  input  5  Read port 0 register index.
- rd_data0  output  N  Read port 0 data (combinational).
- rd_addr1  input  5  Read port 1 register index.
- rd_data1  output  N  Read port 1 data (combinational).

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Storage: registers x1..x31, each N bits. x0 is not a storage element; its mux32 input is tied to N'b0.
- Reset:
  - rst_n low clears x1..x31 to 0 immediately, without waiting for a clock edge.
  - rd_data0 and rd_data1 read 0 for every address while reset is held.
  - A write presented on the same edge on which reset is asserted is discarded.
  - Deassertion is asynchronous. The first write can take effect on the first rising clk with rst_n high.
- Write:
  - On rising clk, if rst_n==1, wr_ena==1 and wr_addr!=0, then register[wr_addr] <= wr_data.
  - All other registers hold their value.
  - wr_ena==0, or wr_addr==0, leaves the state unchanged.
- Write decode: the 5-to-32 one-hot decode of wr_addr is gated by wr_ena. Exactly zero or one register is enabled per cycle.
- Read:
  - rd_dataK = register[rd_addrK], combinational through mux32, zero-cycle latency.
  - Reading address 0 always returns 0.
- Read-during-write, BYPASS=0:
  - A read returns the old value until the rising edge.
  - The new value is visible after the edge, in the same cycle.
- Read-during-write, BYPASS=1:
  - If wr_ena==1, wr_addr!=0 and rd_addrK==wr_addr, then rd_dataK = wr_data, combinationally, in the cycle before the edge.
  - Address 0 is never bypassed and still reads 0.
- Both read ports may address the same register, and either may match wr_addr. The ports are independent and have no arbitration.
- Width rules: no truncation or extension; all data paths are exactly N bits.
- X-handling: an unknown wr_addr with wr_ena==1 is a bench error. The design does not need to protect against it.
- Latency summary:
  - Write-to-read visibility is 1 clock edge, or 0 cycles with BYPASS=1.
  - Read latency is 0 cycles.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing x5=32'hDEADBEEF -> rd_data0 with rd_addr0=5 reads 32'h0 before the next clk edge. All 32 addresses read 0 during reset.
- Write/read all: write reg i = 32'h1000_0000+i for i=1..31 over 31 cycles, then sweep rd_addr0 0..31 and rd_addr1 31..0 -> each returns its written value, and address 0 returns 0 on both ports.
- x0 immunity: wr_ena=1, wr_addr=0, wr_data=32'hFFFF_FFFF -> rd_data0 with rd_addr0=0 stays 0. No other register changes (check x1..x31 unchanged).
- Write enable gating: wr_ena=0, wr_addr=7, wr_data=32'h1234_5678 for 3 cycles -> x7 keeps its prior value 32'h1000_0007.
- Read-during-write, BYPASS=0: x9=32'hAAAA_AAAA, then present wr_ena=1, wr_addr=9, wr_data=32'h5555_5555 with rd_addr0=rd_addr1=9 -> both ports read AAAA_AAAA before the edge and 5555_5555 after it.
- Read-during-write, BYPASS=1: same stimulus as the previous scenario -> both ports read 5555_5555 before the edge. Repeat with wr_addr=0 and rd_addr0=0 -> rd_data0 reads 0.
